// File: rtl/temp_sample_logger.sv
// temp_sample_logger: filters, decimates and averages temperature-diode ADC samples.
// The averaged value is offset-corrected and clamped to 9 bits, then written to the FIFO as 3-digit BCD.
module temp_sample_logger #(
  parameter int CHANNEL    = 17,
  parameter int OFFSET     = 3431,
  parameter int AVG_LOG2   = 3,
  parameter int SAMPLE_DIV = 100000,
  parameter int FILL_LIMIT = 30,
  parameter int USEDW_W    = 5
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               adc_valid,
  input  logic [4:0]         adc_channel,
  input  logic [11:0]        adc_data,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  output logic [11:0]        wr_data,
  output logic               wr_req,
  output logic               logging,
  output logic               result_strobe,
  output logic               overrange,
  output logic               underrange
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {ACC, CONV, WRITE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [11:0]   latch_q, latch_d, avg_q, avg_d, wr_data_q, wr_data_d, bcd_q, bcd_d, diff, bcd_sh;
  logic          have_q, have_d, logging_q, logging_d, over_q, over_d, under_q, under_d;
  logic          pover_q, pover_d, punder_q, punder_d;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    conv_q, conv_d;
  logic [8:0]    bin_q, bin_d, bin_sh, value;
  logic          tick, take, over, under;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACC;
      tick_q    <= '0;
      latch_q   <= '0;
      have_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      conv_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      pover_q   <= 1'b0;
      punder_q  <= 1'b0;
      wr_data_q <= '0;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
      logging_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      latch_q   <= latch_d;
      have_q    <= have_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      conv_q    <= conv_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      pover_q   <= pover_d;
      punder_q  <= punder_d;
      wr_data_q <= wr_data_d;
      over_q    <= over_d;
      under_q   <= under_d;
      logging_q <= logging_d;
    end
  end

  always_comb begin
    tick    = tick_q == TW'(SAMPLE_DIV - 1);
    take    = state_q == ACC && tick && have_q;
    acc_sum = acc_q + AW'(latch_q);
    under   = avg_q < 12'(OFFSET);
    diff    = avg_q - 12'(OFFSET);
    over    = !under && diff > 12'd511;
    value   = under ? 9'd0 : over ? 9'h1ff : diff[8:0];
    // add-3 correction and the shift fused; the carry out of the hundreds nibble is always 0
    {bcd_sh, bin_sh} = {adj(bcd_q[11:8]), adj(bcd_q[7:4]), adj(bcd_q[3:0]), bin_q} << 1;
    tick_d    = tick ? '0 : tick_q + 1'b1;
    latch_d   = adc_valid && adc_channel == 5'(CHANNEL) ? adc_data : latch_q;
    have_d    = (adc_valid && adc_channel == 5'(CHANNEL)) || (have_q && !take);
    logging_d = logging_q ? 32'(fifo_wrusedw) < FILL_LIMIT : fifo_wrusedw == '0;
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    conv_d    = conv_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    pover_d   = pover_q;
    punder_d  = punder_q;
    wr_data_d = wr_data_q;
    over_d    = over_q;
    under_d   = under_q;
    case (state_q)
      ACC: if (take) begin
        acc_d = cnt_q == LAST ? '0 : acc_sum;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          avg_d   = acc_sum[AW-1:AVG_LOG2];
          conv_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        conv_d   = conv_q + 1'b1;
        bin_d    = conv_q == 4'd0 ? value : bin_sh;
        bcd_d    = conv_q == 4'd0 ? 12'd0 : bcd_sh;
        pover_d  = conv_q == 4'd0 ? over : pover_q;
        punder_d = conv_q == 4'd0 ? under : punder_q;
        if (conv_q == 4'd9) begin
          wr_data_d = bcd_sh;
          over_d    = pover_q;
          under_d   = punder_q;
          state_d   = WRITE;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    result_strobe = state_q == WRITE;
    wr_req        = state_q == WRITE && logging_q;
    wr_data       = wr_data_q;
    logging       = logging_q;
    overrange     = over_q;
    underrange    = under_q;
  end
endmodule

// File: tb/tb_temp_sample_logger.sv
// tb_temp_sample_logger: directed phases push expected results; a negedge monitor pops and compares.
module tb_temp_sample_logger;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [4:0]  adc_channel = '0;
  logic [11:0] adc_data = '0;
  logic [4:0]  fifo_wrusedw = '0;
  logic [11:0] wr_data;
  logic        wr_req, logging, result_strobe, overrange, underrange;

  typedef struct {
    logic [11:0] d;
    logic        ov, un, req;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, passed = 0, nstrobe = 0, pc = 0, mode = 0;
  logic [11:0] cval = '0;
  logic prev_req = 1'b0;

  temp_sample_logger #(.SAMPLE_DIV(20), .AVG_LOG2(2)) dut (
    .clock_in(clk), .reset_n(reset_n), .adc_valid(adc_valid), .adc_channel(adc_channel),
    .adc_data(adc_data), .fifo_wrusedw(fifo_wrusedw), .wr_data(wr_data), .wr_req(wr_req),
    .logging(logging), .result_strobe(result_strobe), .overrange(overrange), .underrange(underrange)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) pc <= !reset_n ? 0 : pc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ADC stimulus: 0 idle, 1 constant, 2 alternating per tick window, 3 wrong channel, 4 random
  initial forever begin
    @(negedge clk);
    case (mode)
      1: begin adc_valid = 1'b1; adc_channel = 5'd17; adc_data = cval; end
      2: begin adc_valid = 1'b1; adc_channel = 5'd17; adc_data = ((pc / 20) % 2) != 0 ? 12'd3534 : 12'd3531; end
      3: begin adc_valid = 1'b1; adc_channel = 5'd5; adc_data = 12'd3554; end
      4: begin adc_valid = 1'($urandom); adc_channel = 5'($urandom); adc_data = 12'($urandom); end
      default: adc_valid = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (wr_req) chk("wr_req_single_cycle", int'(prev_req), 0);
      if (wr_req) chk("wr_req_with_strobe", int'(result_strobe), 1);
      prev_req = wr_req;
      if (result_strobe) begin
        nstrobe++;
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_data", int'(wr_data), int'(e.d));
          chk("overrange", int'(overrange), int'(e.ov));
          chk("underrange", int'(underrange), int'(e.un));
          chk("wr_req", int'(wr_req), int'(e.req));
          if (e.cyc >= 0) chk("latency_cycle", pc, e.cyc);
        end
      end
    end else prev_req = 1'b0;
  end

  task automatic push(input logic [11:0] d, input logic ov, input logic un, input logic req, input int cyc);
    exp_t e;
    e.d = d; e.ov = ov; e.un = un; e.req = req; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_n(input int k, input int budget);
    int goal = nstrobe + k;
    int c = 0;
    while (nstrobe < goal && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (nstrobe < goal) chk("result_timeout", nstrobe, goal);
  endtask

  // assert reset now, hold 3 cycles in the given input mode, check reset outputs, release in new_mode
  task automatic do_reset(input int hold_mode, input int new_mode, input logic [11:0] v, input logic [4:0] u);
    reset_n = 1'b0;
    mode = hold_mode;
    fifo_wrusedw = u;
    repeat (3) @(negedge clk);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_logging", int'(logging), 1);
    chk("rst_strobe", int'(result_strobe), 0);
    chk("rst_overrange", int'(overrange), 0);
    chk("rst_underrange", int'(underrange), 0);
    q.delete();
    cval = v;
    mode = new_mode;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n0;
    @(negedge clk);
    do_reset(4, 0, 12'd0, 5'd7);
    fifo_wrusedw = '0;
    n0 = nstrobe;
    repeat (100) @(negedge clk);
    chk("idle_no_result", nstrobe - n0, 0);

    @(negedge clk);
    do_reset(1, 1, 12'd3554, 5'd0);
    push(12'h123, 1'b0, 1'b0, 1'b1, 90);
    push(12'h123, 1'b0, 1'b0, 1'b1, 170);
    wait_n(2, 400);

    @(negedge clk);
    do_reset(2, 2, 12'd0, 5'd0);
    push(12'h101, 1'b0, 1'b0, 1'b1, 90);
    wait_n(1, 200);

    @(negedge clk);
    do_reset(3, 3, 12'd0, 5'd0);
    n0 = nstrobe;
    repeat (1000) @(negedge clk);
    chk("wrong_channel_no_result", nstrobe - n0, 0);

    @(negedge clk);
    do_reset(1, 1, 12'd4095, 5'd0);
    push(12'h511, 1'b1, 1'b0, 1'b1, 90);
    wait_n(1, 200);

    @(negedge clk);
    do_reset(1, 1, 12'd3000, 5'd0);
    push(12'h000, 1'b0, 1'b1, 1'b1, 90);
    wait_n(1, 200);

    @(negedge clk);
    do_reset(1, 1, 12'd3554, 5'd30);
    @(negedge clk);
    chk("logging_falls", int'(logging), 0);
    push(12'h123, 1'b0, 1'b0, 1'b0, 90);
    push(12'h123, 1'b0, 1'b0, 1'b0, 170);
    wait_n(2, 400);
    fifo_wrusedw = 5'd15;
    repeat (2) @(negedge clk);
    chk("logging_holds_at_15", int'(logging), 0);
    fifo_wrusedw = 5'd0;
    @(negedge clk);
    chk("logging_rises_at_0", int'(logging), 1);
    push(12'h123, 1'b0, 1'b0, 1'b1, -1);
    wait_n(1, 200);

    @(negedge clk);
    do_reset(1, 1, 12'd3554, 5'd0);
    n0 = 0;
    while (pc != 84 && n0 < 200) begin
      @(negedge clk);
      n0++;
    end
    chk("reached_mid_conv", pc, 84);
    n0 = nstrobe;
    do_reset(1, 1, 12'd3554, 5'd0);
    chk("abandoned_no_result", nstrobe - n0, 0);
    push(12'h123, 1'b0, 1'b0, 1'b1, 90);
    wait_n(1, 200);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
